// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine credit engine.
package vm_pkg;

    localparam int unsigned STATE_W         = 1;
    localparam int unsigned DEF_CHANGE_STEP = 5;

    localparam logic [STATE_W-1:0] ST_COLLECT = 1'b0;
    localparam logic [STATE_W-1:0] ST_CHANGE  = 1'b1;

endpackage

// File: rtl/addsub_n.sv
// Gate-level N-bit ripple adder/subtractor: sub inverts B and drives the carry-in,
// so subtraction is A + ~B + 1 and carry_out==0 signals a borrow.
module addsub_n #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    logic [N:0]   carry;
    logic [N-1:0] b_eff;

    assign carry[0] = sub;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign b_eff[i]    = b[i] ^ sub;
        assign sum[i]      = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1]  = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    assign carry_out = carry[N];

endmodule

// File: rtl/credit_accumulator.sv
// Vending credit engine: accumulates coins, settles purchases and pays change or a
// refund in bounded beats, all through one time-shared add/sub unit.
module credit_accumulator
    import vm_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned CHANGE_STEP = DEF_CHANGE_STEP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         coin_valid,
    input  logic [N-1:0] coin_value,
    output logic         coin_ready,
    output logic         coin_reject,
    input  logic         price_valid,
    input  logic [N-1:0] price,
    output logic         price_ready,
    output logic         vend_ok,
    output logic         insufficient,
    input  logic         cancel,
    output logic         change_valid,
    output logic [N-1:0] change_amt,
    input  logic         change_ready,
    output logic         change_done,
    output logic [N-1:0] credit,
    output logic         busy
);

    localparam logic [N-1:0] STEP = N'(CHANGE_STEP);

    logic [STATE_W-1:0] state, state_d;
    logic [N-1:0]       credit_d;
    logic               coin_reject_d, vend_ok_d, insufficient_d, change_done_d;

    logic               in_change;
    logic [N-1:0]       step_amt;
    logic [N-1:0]       op_b;
    logic               op_sub;
    logic [N-1:0]       au_sum;
    logic               au_cout;

    addsub_n #(.N(N)) u_addsub (
        .a         (credit),
        .b         (op_b),
        .sub       (op_sub),
        .sum       (au_sum),
        .carry_out (au_cout)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_COLLECT;
            credit       <= '0;
            coin_reject  <= 1'b0;
            vend_ok      <= 1'b0;
            insufficient <= 1'b0;
            change_done  <= 1'b0;
        end else begin
            state        <= state_d;
            credit       <= credit_d;
            coin_reject  <= coin_reject_d;
            vend_ok      <= vend_ok_d;
            insufficient <= insufficient_d;
            change_done  <= change_done_d;
        end
    end

    // Next state, operand select and handshake outputs
    always_comb begin
        state_d        = state;
        credit_d       = credit;
        coin_reject_d  = 1'b0;
        vend_ok_d      = 1'b0;
        insufficient_d = 1'b0;
        change_done_d  = 1'b0;
        op_b           = coin_value;
        op_sub         = 1'b0;

        in_change    = (state == ST_CHANGE);
        step_amt     = (credit < STEP) ? credit : STEP;
        busy         = in_change;
        price_ready  = !in_change;
        coin_ready   = !in_change && !cancel && !price_valid;
        change_valid = in_change;
        change_amt   = in_change ? step_amt : '0;

        if (in_change) begin
            op_b   = step_amt;
            op_sub = 1'b1;
            if (change_ready) begin
                credit_d = au_sum;
                if (au_sum == '0) begin
                    change_done_d = 1'b1;
                    state_d       = ST_COLLECT;
                end
            end
        end else if (cancel) begin
            if (credit != '0) begin
                state_d = ST_CHANGE;
            end
        end else if (price_valid) begin
            op_b   = price;
            op_sub = 1'b1;
            // No borrow means credit >= price
            if (au_cout) begin
                credit_d  = au_sum;
                vend_ok_d = 1'b1;
                if (au_sum == '0) begin
                    change_done_d = 1'b1;
                end else begin
                    state_d = ST_CHANGE;
                end
            end else begin
                insufficient_d = 1'b1;
            end
        end else if (coin_valid) begin
            if (au_cout) begin
                coin_reject_d = 1'b1;
            end else begin
                credit_d = au_sum;
            end
        end
    end

endmodule
